count_seq_checker: RTL and testbench



---
 rtl/count_seq_checker_pkg.sv | 17 +
 rtl/mod_next.sv | 26 ++
 rtl/count_seq_checker.sv | 164 ++++++++++++++++
 tb/tb_count_seq_checker.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/count_seq_checker_pkg.sv
// Shared types and default constants for the counter sequence checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package count_check_pkg;

    // Default geometry of the lab counter under test
    localparam int CNT_WIDTH   = 10;
    localparam int CNT_MODULUS = 1000;

    // Checker FSM encoding
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/mod_next.sv
// Combinational modulo incrementer: o_next = (i_cur == MODULUS-1) ? 0 : i_cur + 1.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input continuously.
module mod_next
    import count_check_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH,
    parameter int MODULUS = CNT_MODULUS
) (
    input  logic [WIDTH-1:0] i_cur,
    output logic [WIDTH-1:0] o_next
);

    // Terminal count of the sequence, sized to the bus so the compare is exact
    localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(MODULUS - 1);

    // Wrap to zero at the terminal count; otherwise a plain increment that cannot overflow
    always_comb begin
        if (i_cur == LAST_VAL) begin
            o_next = '0;
        end else begin
            o_next = i_cur + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_seq_checker.sv
// Locks onto a free-running modulo count and flags every break in the +1 sequence.
// Latency: all outputs registered; a sample taken at edge k is reflected right after edge k.
// Backpressure: none; the bus is sampled unconditionally every clock.
module count_seq_checker
    import count_check_pkg::*;
#(
    parameter int WIDTH      = CNT_WIDTH,
    parameter int MODULUS    = CNT_MODULUS,
    parameter int LOCK_COUNT = 4,
    parameter int TALLY_W    = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   q_in,
    output logic               locked,
    output logic               err,
    output logic               wrap,
    output logic [TALLY_W-1:0] err_count,
    output logic [TALLY_W-1:0] wrap_count,
    output logic [WIDTH-1:0]   last_bad
);

    // LOCK_COUNT tops out at 15, so four bits always hold the match run
    localparam int MATCH_W = 4;
    localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_COUNT);
    // Modulus widened by one bit so MODULUS == 2**WIDTH still compares correctly
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_prev;
    logic [WIDTH-1:0]     w_prev_nxt;
    logic [MATCH_W-1:0]   r_match;
    logic [MATCH_W-1:0]   w_match_nxt;
    logic [MATCH_W-1:0]   w_match_inc;
    logic [WIDTH-1:0]     r_last_bad;
    logic [WIDTH-1:0]     w_last_bad_nxt;
    logic                 r_err;
    logic                 r_wrap;
    logic                 w_err_nxt;
    logic                 w_wrap_nxt;
    logic [TALLY_W-1:0]   r_err_count;
    logic [TALLY_W-1:0]   r_wrap_count;
    logic [WIDTH-1:0]     w_expected;
    logic                 w_in_range;
    logic                 w_hit;

    mod_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_mod_next (
        .i_cur  (r_prev),
        .o_next (w_expected)
    );

    // Sample classification against the last accepted value
    assign w_in_range  = ({1'b0, q_in} < MOD_EXT);
    assign w_hit       = (q_in == w_expected);
    assign w_match_inc = r_match + MATCH_W'(1);

    // Next-state, next-datapath and strobe decode for the lock FSM
    always_comb begin
        w_state_nxt    = r_state;
        w_prev_nxt     = r_prev;
        w_match_nxt    = r_match;
        w_last_bad_nxt = r_last_bad;
        w_err_nxt      = 1'b0;
        w_wrap_nxt     = 1'b0;
        case (r_state)
            ST_SYNC: begin
                // Any legal value seeds the sequence; garbage is ignored
                if (w_in_range) begin
                    w_prev_nxt  = q_in;
                    w_match_nxt = '0;
                    w_state_nxt = ST_ACQ;
                end
            end
            ST_ACQ: begin
                // Acquisition is silent: mismatches only restart the run
                if (w_hit) begin
                    w_prev_nxt  = q_in;
                    w_match_nxt = w_match_inc;
                    if (w_match_inc == LOCK_TGT) begin
                        w_state_nxt = ST_LOCKED;
                    end
                end else if (w_in_range) begin
                    w_prev_nxt  = q_in;
                    w_match_nxt = '0;
                end else begin
                    w_state_nxt = ST_SYNC;
                end
            end
            ST_LOCKED: begin
                if (w_hit) begin
                    w_prev_nxt = q_in;
                    // A hit on zero can only come from MODULUS-1, i.e. a legal wrap
                    w_wrap_nxt = (q_in == '0);
                end else begin
                    w_err_nxt      = 1'b1;
                    w_last_bad_nxt = q_in;
                    if (w_in_range) begin
                        w_prev_nxt  = q_in;
                        w_match_nxt = '0;
                        w_state_nxt = ST_ACQ;
                    end else begin
                        w_state_nxt = ST_SYNC;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sequence tracking registers and single-cycle strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev     <= '0;
            r_match    <= '0;
            r_last_bad <= '0;
            r_err      <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_prev     <= w_prev_nxt;
            r_match    <= w_match_nxt;
            r_last_bad <= w_last_bad_nxt;
            r_err      <= w_err_nxt;
            r_wrap     <= w_wrap_nxt;
        end
    end

    // Saturating tallies: the increment and the all-ones hold resolve in the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_count  <= '0;
            r_wrap_count <= '0;
        end else begin
            if (w_err_nxt && !(&r_err_count)) begin
                r_err_count <= r_err_count + TALLY_W'(1);
            end
            if (w_wrap_nxt && !(&r_wrap_count)) begin
                r_wrap_count <= r_wrap_count + TALLY_W'(1);
            end
        end
    end

    assign locked     = (r_state == ST_LOCKED);
    assign err        = r_err;
    assign wrap       = r_wrap;
    assign err_count  = r_err_count;
    assign wrap_count = r_wrap_count;
    assign last_bad   = r_last_bad;

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed bench for count_seq_checker with 4-bit tallies to reach saturation quickly.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
// No flow control on the DUT; each step is exactly one clock.
module tb_count_seq_checker;

    localparam int W  = 10;
    localparam int TW = 4;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  q_in;
    logic          locked;
    logic          err;
    logic          wrap;
    logic [TW-1:0] err_count;
    logic [TW-1:0] wrap_count;
    logic [W-1:0]  last_bad;

    int total;
    int bad;
    int err_seen;
    int wrap_seen;

    count_seq_checker #(
        .WIDTH      (W),
        .MODULUS    (1000),
        .LOCK_COUNT (4),
        .TALLY_W    (TW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .q_in       (q_in),
        .locked     (locked),
        .err        (err),
        .wrap       (wrap),
        .err_count  (err_count),
        .wrap_count (wrap_count),
        .last_bad   (last_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Present one sample, clock it in, and settle just after the edge
    task automatic step(input int v);
        q_in = W'(v);
        @(posedge clk);
        #1;
        err_seen  += int'(err);
        wrap_seen += int'(wrap);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        err_seen  = 0;
        wrap_seen = 0;
        reset_n   = 1'b0;
        q_in      = '0;

        // Reset held for 3 cycles while the bus moves
        for (int i = 0; i < 3; i++) step(i * 7 + 3);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_wrap_count", 32'(wrap_count), 32'd0);
        chk("rst_last_bad", 32'(last_bad), 32'd0);

        // Lock on 0..4: locked after the edge sampling 4
        reset_n  = 1'b1;
        err_seen = 0;
        for (int v = 0; v < 4; v++) step(v);
        chk("lock_pre", 32'(locked), 32'd0);
        step(4);
        chk("lock_up", 32'(locked), 32'd1);
        chk("lock_no_err", 32'(err_seen), 32'd0);

        // Full wrap run: one wrap pulse, on the sample of 0
        err_seen  = 0;
        wrap_seen = 0;
        for (int v = 5; v < 1000; v++) step(v);
        step(0);
        chk("wrap_pulse", 32'(wrap), 32'd1);
        step(1);
        chk("wrap_drop", 32'(wrap), 32'd0);
        chk("wrap_seen", 32'(wrap_seen), 32'd1);
        chk("wrap_err_seen", 32'(err_seen), 32'd0);
        chk("wrap_count", 32'(wrap_count), 32'd1);
        chk("wrap_err_count", 32'(err_count), 32'd0);
        chk("wrap_locked", 32'(locked), 32'd1);

        // Skip 11: error, drop lock, relock after 13..16
        for (int v = 2; v <= 10; v++) step(v);
        step(12);
        chk("skip_err", 32'(err), 32'd1);
        chk("skip_err_count", 32'(err_count), 32'd1);
        chk("skip_last_bad", 32'(last_bad), 32'd12);
        chk("skip_locked", 32'(locked), 32'd0);
        step(13);
        chk("skip_err_drop", 32'(err), 32'd0);
        step(14);
        step(15);
        chk("skip_prelock", 32'(locked), 32'd0);
        step(16);
        chk("skip_relock", 32'(locked), 32'd1);

        // Out of range while locked, then silent resync through 5,7..11
        step(1000);
        chk("oor_err", 32'(err), 32'd1);
        chk("oor_last_bad", 32'(last_bad), 32'd1000);
        chk("oor_err_count", 32'(err_count), 32'd2);
        chk("oor_locked", 32'(locked), 32'd0);
        step(1001);
        chk("sync_no_err", 32'(err), 32'd0);
        err_seen = 0;
        step(5);
        for (int v = 7; v <= 10; v++) step(v);
        chk("acq_prelock", 32'(locked), 32'd0);
        step(11);
        chk("acq_lock", 32'(locked), 32'd1);
        chk("acq_no_err", 32'(err_seen), 32'd0);

        // Out of range again, then relock on 0..4
        step(1000);
        chk("oor2_err_count", 32'(err_count), 32'd3);
        for (int v = 0; v <= 4; v++) step(v);
        chk("oor2_relock", 32'(locked), 32'd1);

        // Counter reset mid-run: 523 -> 0 is an error, not a wrap
        for (int v = 5; v <= 523; v++) step(v);
        step(0);
        chk("crst_err", 32'(err), 32'd1);
        chk("crst_wrap", 32'(wrap), 32'd0);
        chk("crst_last_bad", 32'(last_bad), 32'd0);
        chk("crst_err_count", 32'(err_count), 32'd4);
        chk("crst_wrap_count", 32'(wrap_count), 32'd1);
        chk("crst_locked", 32'(locked), 32'd0);

        // Asynchronous reset mid-cycle while locked
        for (int v = 1; v <= 4; v++) step(v);
        chk("arst_pre_locked", 32'(locked), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        chk("arst_wrap_count", 32'(wrap_count), 32'd0);
        chk("arst_last_bad", 32'(last_bad), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Saturation: 20 locked violations, tally holds at 15
        for (int i = 0; i < 20; i++) begin
            for (int v = 0; v <= 4; v++) step(v);
            chk("sat_lock", 32'(locked), 32'd1);
            step(1023);
            chk("sat_err", 32'(err), 32'd1);
            chk("sat_err_count", 32'(err_count), (i + 1 > 15) ? 32'd15 : 32'(i + 1));
        end
        chk("sat_last_bad", 32'(last_bad), 32'd1023);
        chk("sat_wrap_count", 32'(wrap_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
